ts4231_multi_configurator: RTL
==============================

Name: ts4231_multi_configurator

Overview:
- Parametrised successor to the single-sensor TS4231 configurator; configures N_CH TS4231 light-sensor front-ends one after another over their D/E bidirectional pins.
- Additions: configurable word/width/bit timing, configuration readback with compare, bounded retry, light-wait timeout, per-channel status.
- Sits between pin tristate buffers and the lighthouse pulse decoder; decoder ignores a channel until its configured bit is set.

Parameters:
N_CH, 4, number of sensor channels (1..8)
WORD_BITS, 15, configuration word length, shifted MSB first
CONFIG_WORD, 15'h392B, value written to every sensor
TICK_DIV, 24, clk cycles per protocol tick (>=2)
START_TICKS, 5, ticks E is released after the light pulse before E is driven
LIGHT_TIMEOUT, 65535, ticks to wait for a D falling edge before giving up on that attempt
MAX_RETRY, 3, extra attempts per channel after a failed attempt

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
reconfigure  in  1  rising edge (sampled every clk) starts a run over all channels
busy  out  1  run in progress
configured  out  N_CH  per-channel success flag
failed  out  N_CH  per-channel failure flag (retries exhausted)
last_readback  out  WORD_BITS  word read back on the most recent attempt
d_in  in  N_CH  sensor D pins
d_out  out  N_CH  D drive value
d_oe  out  N_CH  D output enable
e_in  in  N_CH  sensor E pins
e_out  out  N_CH  E drive value
e_oe  out  N_CH  E output enable

Behaviour:
- Reset: busy=0, configured=0, failed=0, last_readback=0, tick counter=0, FSM=IDLE, all channels released (d_oe=0, d_out=0, e_oe=0, e_out=1). Reset mid-run aborts immediately; pins released the cycle after reset asserts.
- Tick: single-cycle pulse every TICK_DIV clk, free-running, cleared by reset. The FSM advances only on tick cycles, except IDLE, which reacts to the reconfigure edge on any clk.
- Only channel ch (current index) is driven; all other channels are held released. d_in/e_in of ch are sampled on ticks; the previous-D register is reset when ch advances.
- IDLE: on reconfigure rising edge, clear configured/failed, ch=0, retry=0, busy=1 -> WAIT_PULSE. Edges while busy are ignored.
- WAIT_PULSE: released. D 1->0 between consecutive ticks -> START_WAIT. Timeout counter reaching LIGHT_TIMEOUT counts as a failed attempt.
- START_WAIT: START_TICKS ticks released; on the last tick e_oe=1, e_out=1 -> WR_START.
- WR_START (E1,D0) -> per bit, MSB first: WR_E_LOW (E0, D=bit) -> WR_BIT (E0, D=bit) -> WR_E_HIGH (E1, D=bit). After bit 0 -> WR_STOP (E1,D1).
- RD_START (E1,D0) -> per bit: RD_E_LOW (E0, D released) -> RD_E_HIGH (E1, D released); sample d_in[ch] on the RD_E_HIGH tick, shift in MSB first. After WORD_BITS bits -> RD_STOP (E1,D1), copy the shift register to last_readback.
- WATCH_ELOW (E0,D1) -> WATCH_DLOW (E0,D0) -> WATCH_EHIGH (E1,D0) -> CHECK.
- CHECK (released): readback==CONFIG_WORD -> set configured[ch] -> NEXT. Mismatch or timeout: retry<MAX_RETRY -> retry+1, back to WAIT_PULSE; otherwise set failed[ch] -> NEXT.
- NEXT: retry=0. ch==N_CH-1 -> busy=0, IDLE. Otherwise ch+1 -> WAIT_PULSE.
- Pin outputs are combinational from state/ch/bit, with no glitch between ticks.
- Per channel, configured and failed are never both 1. Flags persist until the next run or reset.

Test Plan:
- N_CH=2, sensor models echo the written word. Pulse reconfigure, D pulse on each channel -> exactly 15 E rising edges carrying 0x392B MSB first per channel; configured=2'b11, failed=0, busy falls after ch1 WATCH_EHIGH+CHECK+NEXT.
- Channel 0 echo corrupts bit 3 on the first readback only -> one retry; configured[0]=1, last_readback=15'h392B at end, total 2 write sequences observed on ch0.
- Channel 1 never pulses D, LIGHT_TIMEOUT=100, MAX_RETRY=1 -> failed[1]=1 after 2x100 ticks, configured[1]=0, ch1 pins released throughout.
- Second reconfigure edge during run -> ignored; run completes once. New edge after busy=0 clears flags and reruns.
- Reset asserted mid WR_BIT of ch0 -> next clk all oe=0, e_out=1, status cleared, busy=0. No activity until a new reconfigure edge.
- Non-active channels: throughout any run, d_oe/e_oe of idle channels stay 0 every cycle (assertion).

Source files
------------

// File: rtl/ts4231_multi_configurator.sv
// Configures N_CH TS4231 light-sensor front-ends one at a time over their
// D/E pins: wait for a light pulse, write the config word, read it back,
// switch the sensor to watch mode, then compare and retry if needed.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// IDLE        | pins released, waiting for a reconfigure rising edge
// WAIT_PULSE  | released, waiting for D 1->0 on the current channel
// START_WAIT  | released for START_TICKS ticks; E driven high on the last
// WR_START    | write start condition (E1, D0)
// WR_E_LOW    | E low, D carries the current bit
// WR_BIT      | E low, D held on the current bit
// WR_E_HIGH   | E rising edge latches the bit into the sensor
// WR_STOP     | write stop condition (E1, D1)
// RD_START    | read start condition (E1, D0)
// RD_E_LOW    | E low, sensor presents the next bit on D
// RD_E_HIGH   | E high, D sampled at the end of this state
// RD_STOP     | read stop condition (E1, D1), readback latched
// WATCH_ELOW  | watch-mode entry, E low with D high
// WATCH_DLOW  | watch-mode entry, D low
// WATCH_EHIGH | watch-mode entry, E high with D low
// CHECK       | compare readback, decide success / retry / failure
// NEXT        | advance to the next channel or finish the run
module ts4231_multi_configurator #(
  parameter int N_CH = 4,
  parameter int WORD_BITS = 15,
  parameter logic [WORD_BITS-1:0] CONFIG_WORD = 15'h392B,
  parameter int TICK_DIV = 24,
  parameter int START_TICKS = 5,
  parameter int LIGHT_TIMEOUT = 65535,
  parameter int MAX_RETRY = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 reconfigure,
  output logic                 busy,
  output logic [N_CH-1:0]      configured,
  output logic [N_CH-1:0]      failed,
  output logic [WORD_BITS-1:0] last_readback,
  input  logic [N_CH-1:0]      d_in,
  output logic [N_CH-1:0]      d_out,
  output logic [N_CH-1:0]      d_oe,
  input  logic [N_CH-1:0]      e_in,
  output logic [N_CH-1:0]      e_out,
  output logic [N_CH-1:0]      e_oe
);

  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int BIT_W  = $clog2(WORD_BITS);
  localparam int TICK_W = $clog2(TICK_DIV);
  localparam int TMR_W  = $clog2(LIGHT_TIMEOUT + START_TICKS + 1);
  localparam int RTY_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [4:0] {
    IDLE, WAIT_PULSE, START_WAIT,
    WR_START, WR_E_LOW, WR_BIT, WR_E_HIGH, WR_STOP,
    RD_START, RD_E_LOW, RD_E_HIGH, RD_STOP,
    WATCH_ELOW, WATCH_DLOW, WATCH_EHIGH,
    CHECK, NEXT
  } state_t;

  state_t               state, state_nx;
  logic [TICK_W-1:0]    tick_cnt;
  logic                 tick;
  logic                 recon_q;
  logic                 recon_edge;
  logic [CH_W-1:0]      ch;
  logic [RTY_W-1:0]     retry;
  logic [BIT_W-1:0]     bit_idx;
  logic [TMR_W-1:0]     tmr;
  logic [WORD_BITS-1:0] shift_q;
  logic [WORD_BITS-1:0] shift_nx;
  logic                 d_prev;
  logic                 d_fall;
  logic                 timed_out;
  logic                 attempt_ok;
  logic                 cur_bit;
  logic                 a_doe, a_dout, a_eoe, a_eout;

  // E is only ever driven by this block; its pin readback carries no
  // information the sequencer needs.
  logic unused_e;
  assign unused_e = ^e_in;

  assign tick       = (tick_cnt == '0);
  assign recon_edge = reconfigure & ~recon_q;
  assign d_fall     = d_prev & ~d_in[ch];
  assign shift_nx   = {shift_q[WORD_BITS-2:0], d_in[ch]};
  assign cur_bit    = CONFIG_WORD[bit_idx];
  assign attempt_ok = ~timed_out && (last_readback == CONFIG_WORD);

  // Free-running protocol tick divider and reconfigure edge history.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt <= '0;
      recon_q  <= 1'b0;
    end else begin
      recon_q  <= reconfigure;
      tick_cnt <= tick ? TICK_W'(TICK_DIV - 1) : tick_cnt - 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state decode and pin drive for the active channel.
  always_comb begin
    state_nx = state;
    a_doe  = 1'b0;
    a_dout = 1'b0;
    a_eoe  = 1'b0;
    a_eout = 1'b1;
    case (state)
      IDLE:        if (recon_edge) state_nx = WAIT_PULSE;
      WAIT_PULSE: begin
        if (tick) begin
          if (d_fall)         state_nx = START_WAIT;
          else if (tmr == '0) state_nx = CHECK;
        end
      end
      START_WAIT: begin
        if (tmr == '0) begin
          a_eoe = 1'b1;
          if (tick) state_nx = WR_START;
        end
      end
      WR_START: begin
        a_eoe = 1'b1; a_doe = 1'b1;
        if (tick) state_nx = WR_E_LOW;
      end
      WR_E_LOW: begin
        a_eoe = 1'b1; a_eout = 1'b0; a_doe = 1'b1; a_dout = cur_bit;
        if (tick) state_nx = WR_BIT;
      end
      WR_BIT: begin
        a_eoe = 1'b1; a_eout = 1'b0; a_doe = 1'b1; a_dout = cur_bit;
        if (tick) state_nx = WR_E_HIGH;
      end
      WR_E_HIGH: begin
        a_eoe = 1'b1; a_doe = 1'b1; a_dout = cur_bit;
        if (tick) state_nx = (bit_idx == '0) ? WR_STOP : WR_E_LOW;
      end
      WR_STOP: begin
        a_eoe = 1'b1; a_doe = 1'b1; a_dout = 1'b1;
        if (tick) state_nx = RD_START;
      end
      RD_START: begin
        a_eoe = 1'b1; a_doe = 1'b1;
        if (tick) state_nx = RD_E_LOW;
      end
      RD_E_LOW: begin
        a_eoe = 1'b1; a_eout = 1'b0;
        if (tick) state_nx = RD_E_HIGH;
      end
      RD_E_HIGH: begin
        a_eoe = 1'b1;
        if (tick) state_nx = (bit_idx == '0) ? RD_STOP : RD_E_LOW;
      end
      RD_STOP: begin
        a_eoe = 1'b1; a_doe = 1'b1; a_dout = 1'b1;
        if (tick) state_nx = WATCH_ELOW;
      end
      WATCH_ELOW: begin
        a_eoe = 1'b1; a_eout = 1'b0; a_doe = 1'b1; a_dout = 1'b1;
        if (tick) state_nx = WATCH_DLOW;
      end
      WATCH_DLOW: begin
        a_eoe = 1'b1; a_eout = 1'b0; a_doe = 1'b1;
        if (tick) state_nx = WATCH_EHIGH;
      end
      WATCH_EHIGH: begin
        a_eoe = 1'b1; a_doe = 1'b1;
        if (tick) state_nx = CHECK;
      end
      CHECK: begin
        if (tick) begin
          if (!attempt_ok && retry < RTY_W'(MAX_RETRY)) state_nx = WAIT_PULSE;
          else                                            state_nx = NEXT;
        end
      end
      NEXT:    if (tick) state_nx = (ch == CH_W'(N_CH - 1)) ? IDLE : WAIT_PULSE;
      default: state_nx = IDLE;
    endcase
    d_oe      = '0;
    d_out     = '0;
    e_oe      = '0;
    e_out     = '1;
    d_oe[ch]  = a_doe;
    d_out[ch] = a_dout;
    e_oe[ch]  = a_eoe;
    e_out[ch] = a_eout;
  end

  // Sequencing datapath: channel/retry/bit indices, timers, shift register, status.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy          <= 1'b0;
      configured    <= '0;
      failed        <= '0;
      last_readback <= '0;
      ch            <= '0;
      retry         <= '0;
      bit_idx       <= '0;
      tmr           <= '0;
      shift_q       <= '0;
      d_prev        <= 1'b0;
      timed_out     <= 1'b0;
    end else if (state == IDLE) begin
      if (recon_edge) begin
        busy       <= 1'b1;
        configured <= '0;
        failed     <= '0;
        ch         <= '0;
        retry      <= '0;
        tmr        <= TMR_W'(LIGHT_TIMEOUT - 1);
        d_prev     <= 1'b0;
        timed_out  <= 1'b0;
      end
    end else if (tick) begin
      case (state)
        WAIT_PULSE: begin
          d_prev <= d_in[ch];
          if (d_fall)         tmr <= TMR_W'(START_TICKS - 1);
          else if (tmr == '0) timed_out <= 1'b1;
          else                tmr <= tmr - 1'b1;
        end
        START_WAIT: if (tmr != '0) tmr <= tmr - 1'b1;
        WR_START:   bit_idx <= BIT_W'(WORD_BITS - 1);
        WR_E_HIGH:  if (bit_idx != '0) bit_idx <= bit_idx - 1'b1;
        RD_START:   bit_idx <= BIT_W'(WORD_BITS - 1);
        RD_E_HIGH: begin
          shift_q <= shift_nx;
          if (bit_idx == '0) last_readback <= shift_nx;
          else               bit_idx <= bit_idx - 1'b1;
        end
        CHECK: begin
          d_prev    <= 1'b0;
          timed_out <= 1'b0;
          tmr       <= TMR_W'(LIGHT_TIMEOUT - 1);
          if (attempt_ok)                         configured[ch] <= 1'b1;
          else if (retry < RTY_W'(MAX_RETRY))     retry <= retry + 1'b1;
          else                                    failed[ch] <= 1'b1;
        end
        NEXT: begin
          retry <= '0;
          if (ch == CH_W'(N_CH - 1)) busy <= 1'b0;
          else                       ch <= ch + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
